multicycle_ctrl: RTL

Multi-cycle control FSM for the 16-bit ISA core. Holds the instruction register, decodes the 4-bit opcode, and drives the register file (select1/select2/select3, RegDst, RegWrite), ALU, data memory and PC strobes state by state. Sits between instruction memory and the datapath. It is the only source of RegWrite.

---
 rtl/multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the 16-bit ISA core.
// Holds the instruction register, sequences FETCH/DECODE/EXEC/MEM/WB/HALT,
// and drives the register-file, ALU, data-memory and PC strobes.
// Optional build macro ILLEGAL_TRAP_EN: illegal opcodes (9-E) trap into HALT
// with illegal=1; without it they retire as NOPs and illegal is tied to 0.
// Strobes are decoded combinationally from state/IR and forced low while rst
// is high, so a reset asserted mid-access drops them in that same cycle.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    instr,
  input  logic             instr_valid,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic [3:0]       select1,
  output logic [3:0]       select2,
  output logic [3:0]       select3,
  output logic             RegDst,
  output logic             RegWrite,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire_c;
  logic [3:0]       op;
  logic             is_rtype;
  logic             is_illegal;
  logic [2:0]       alu_op_dec;
  logic             alu_src_dec;

  assign op         = ir_q[15:12];
  assign select1    = ir_q[11:8];
  assign select2    = ir_q[7:4];
  assign select3    = ir_q[3:0];
  assign is_rtype   = (op <= OP_OR);
  assign is_illegal = (op > OP_J) && (op != OP_HALT);
  assign RegDst     = is_rtype;
  assign halted     = (state_q == ST_HALT);
  assign retire_cnt = cnt_q;

  // State, instruction register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_q + CNT_W'(retire_c);
    end
  end

  // ALU control from the opcode; memory ops compute rs+imm.
  always_comb begin
    alu_op_dec  = ALU_ADD;
    alu_src_dec = 1'b0;
    case (op)
      OP_SUB:                 alu_op_dec = ALU_SUB;
      OP_AND:                 alu_op_dec = ALU_AND;
      OP_OR:                  alu_op_dec = ALU_OR;
      OP_BEQ:                 alu_op_dec = ALU_SUB;
      OP_ADDI, OP_LW, OP_SW:  alu_src_dec = 1'b1;
      default:                alu_op_dec = ALU_ADD;
    endcase
  end

  // Next-state, strobes and retire pulse.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    retire_c   = 1'b0;
    RegWrite   = 1'b0;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (op == OP_J) begin
          pc_load  = 1'b1;
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          retire_c = 1'b1;
          state_d  = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op  = alu_op_dec;
        alu_src = alu_src_dec;
        if (op == OP_BEQ) begin
          pc_load  = alu_zero;
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        alu_op    = alu_op_dec;
        alu_src   = alu_src_dec;
        mem_read  = (op == OP_LW);
        mem_write = (op == OP_SW);
        if (mem_ready) begin
          if (op == OP_SW) begin
            retire_c = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        alu_op     = alu_op_dec;
        alu_src    = alu_src_dec;
        RegWrite   = 1'b1;
        mem_to_reg = (op == OP_LW);
        retire_c   = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    if (rst) begin
      retire_c   = 1'b0;
      RegWrite   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky trap flag, set when an illegal opcode is decoded.
  always_comb begin
    illegal_d = illegal_q;
    if ((state_q == ST_DECODE) && is_illegal) begin
      illegal_d = 1'b1;
    end
  end

  // Trap flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
